// File: rtl/ether_pkg.sv
// Shared definitions for the RMII receive front end: FSM states and the
// dibit values that mark the preamble and the start-of-frame delimiter.
package ether_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    DROP     = 2'd3
  } state_e;

  localparam logic [1:0] PREAMBLE_DIBIT = 2'b01;
  localparam logic [1:0] SFD_DIBIT      = 2'b11;

endpackage

// File: rtl/ether_rx.sv
// RMII receive framer: strips preamble/SFD, forwards frame dibits with one
// cycle of latency, and reports frame completion (done) or violations (err).
module ether_rx
  import ether_pkg::*;
#(
  parameter int MIN_PRE_DIBITS = 28,
  parameter int LEN_BITS       = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                crsdv,
  input  logic [1:0]          rxd,
  output logic                axiov,
  output logic [1:0]          axiod,
  output logic                done,
  output logic                err,
  output logic [LEN_BITS-1:0] frame_bytes
);

  localparam int PRE_W = $clog2(MIN_PRE_DIBITS + 4);
  localparam int CNT_W = LEN_BITS + 2;

  localparam logic [PRE_W-1:0] PRE_MAX = '1;
  localparam logic [PRE_W-1:0] PRE_MIN = PRE_W'(MIN_PRE_DIBITS);
  localparam logic [CNT_W-1:0] RUNT_DIBITS = CNT_W'(4);

  state_e              r_state;
  logic [PRE_W-1:0]    r_pre_cnt;
  logic [CNT_W-1:0]    r_dibit_cnt;
  logic                r_axiov;
  logic [1:0]          r_axiod;
  logic                r_done;
  logic                r_err;
  logic [LEN_BITS-1:0] r_frame_bytes;

  state_e              w_state_next;
  logic [PRE_W-1:0]    w_pre_cnt_next;
  logic [CNT_W-1:0]    w_dibit_cnt_next;
  logic                w_done_next;
  logic                w_err_next;
  logic                w_fwd;

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; otherwise synthesis would infer a latch to hold its value.
  always_comb begin
    w_state_next     = r_state;
    w_pre_cnt_next   = r_pre_cnt;
    w_dibit_cnt_next = r_dibit_cnt;
    w_done_next      = 1'b0;
    w_err_next       = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_pre_cnt_next = '0;
        if (crsdv) begin
          if (rxd == PREAMBLE_DIBIT) begin
            w_state_next   = PREAMBLE;
            w_pre_cnt_next = PRE_W'(1);
          end else begin
            w_state_next = DROP;
            w_err_next   = 1'b1;
          end
        end
      end

      PREAMBLE: begin
        if (!crsdv) begin
          w_state_next   = IDLE;
          w_pre_cnt_next = '0;
        end else if (rxd == PREAMBLE_DIBIT) begin
          if (r_pre_cnt != PRE_MAX) begin
            w_pre_cnt_next = r_pre_cnt + PRE_W'(1);
          end
        end else if (rxd == SFD_DIBIT && r_pre_cnt >= PRE_MIN) begin
          // The SFD itself is consumed here; counting starts with the next dibit.
          w_state_next     = DATA;
          w_pre_cnt_next   = '0;
          w_dibit_cnt_next = '0;
        end else begin
          w_state_next   = DROP;
          w_pre_cnt_next = '0;
          w_err_next     = 1'b1;
        end
      end

      DATA: begin
        if (crsdv) begin
          w_dibit_cnt_next = r_dibit_cnt + CNT_W'(1);
        end else begin
          w_state_next = IDLE;
          if (r_dibit_cnt >= RUNT_DIBITS) begin
            w_done_next = 1'b1;
          end else begin
            w_err_next = 1'b1;
          end
        end
      end

      DROP: begin
        if (!crsdv) begin
          w_state_next = IDLE;
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign w_fwd = (r_state == DATA) && crsdv;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_pre_cnt     <= '0;
      r_dibit_cnt   <= '0;
      r_axiov       <= 1'b0;
      r_axiod       <= 2'b00;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_frame_bytes <= '0;
    end else begin
      r_state     <= w_state_next;
      r_pre_cnt   <= w_pre_cnt_next;
      r_dibit_cnt <= w_dibit_cnt_next;
      r_axiov     <= w_fwd;
      r_axiod     <= rxd;
      r_done      <= w_done_next;
      r_err       <= w_err_next;
      if (w_done_next) begin
        r_frame_bytes <= r_dibit_cnt[CNT_W-1:2];
      end
    end
  end

  assign axiov       = r_axiov;
  assign axiod       = r_axiod;
  assign done        = r_done;
  assign err         = r_err;
  assign frame_bytes = r_frame_bytes;

endmodule

// File: tb/tb_ether_rx.sv
// Scoreboard bench for ether_rx: frames are parsed by a frame-level reference
// model, expectations queued with their cycle, and a monitor checks outputs.
module tb_ether_rx;

  localparam int MIN_PRE  = 28;
  localparam int LEN_BITS = 12;

  logic                clk = 1'b0;
  logic                rst;
  logic                crsdv;
  logic [1:0]          rxd;
  logic                axiov;
  logic [1:0]          axiod;
  logic                done;
  logic                err;
  logic [LEN_BITS-1:0] frame_bytes;

  ether_rx #(
    .MIN_PRE_DIBITS(MIN_PRE),
    .LEN_BITS      (LEN_BITS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .crsdv      (crsdv),
    .rxd        (rxd),
    .axiov      (axiov),
    .axiod      (axiod),
    .done       (done),
    .err        (err),
    .frame_bytes(frame_bytes)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  typedef struct {int cyc; logic [1:0] d;} dexp_t;
  typedef struct {int cyc; bit is_done; int bytes;} ev_t;

  dexp_t exp_data[$];
  ev_t   exp_ev[$];
  dexp_t m_d;
  ev_t   m_e;

  // Monitor: outputs sampled on the falling edge, edge_cnt names the edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (axiov) begin
        if (exp_data.size() == 0) begin
          check("spurious_axiov", axiov, 0);
        end else begin
          m_d = exp_data.pop_front();
          check("axiov_cycle", edge_cnt, m_d.cyc);
          check("axiod", axiod, m_d.d);
        end
      end else if (exp_data.size() > 0 && exp_data[0].cyc <= edge_cnt) begin
        m_d = exp_data.pop_front();
        check("missed_axiov", axiov, 1);
      end

      if (done && err) check("done_err_overlap", done & err, 0);

      if (done || err) begin
        if (exp_ev.size() == 0) begin
          check("spurious_event", {done, err}, 0);
        end else begin
          m_e = exp_ev.pop_front();
          check("event_cycle", edge_cnt, m_e.cyc);
          check("event_kind", {done, err}, m_e.is_done ? 2 : 1);
          if (m_e.is_done) check("frame_bytes", frame_bytes, m_e.bytes);
        end
      end else if (exp_ev.size() > 0 && exp_ev[0].cyc <= edge_cnt) begin
        m_e = exp_ev.pop_front();
        check("missed_event", {done, err}, m_e.is_done ? 2 : 1);
      end
    end
  end

  // Frame-level model: kind 0 = silent, 1 = done, 2 = err; ev_idx is the
  // dibit slot (n = the first idle slot) whose capture edge raises the pulse.
  function automatic void model(input logic [1:0] f[$], output int kind,
                                output int ev_idx, output int bytes,
                                output int ds, output int dl);
    int n = f.size();
    int i = 0;
    kind = 0; ev_idx = 0; bytes = 0; ds = 0; dl = 0;
    while (i < n && f[i] == 2'b01) i++;
    if (i == n) return;
    if (f[i] == 2'b11 && i >= MIN_PRE) begin
      ds = i + 1;
      dl = n - i - 1;
      ev_idx = n;
      if (dl >= 4) begin
        kind  = 1;
        bytes = (dl % (1 << (LEN_BITS + 2))) / 4;
      end else begin
        kind = 2;
      end
    end else begin
      kind   = 2;
      ev_idx = i;
    end
  endfunction

  logic [1:0] fr[$];

  task automatic add(input int n, input logic [1:0] d);
    repeat (n) fr.push_back(d);
  endtask

  task automatic add_rand(input int n);
    repeat (n) fr.push_back(2'($urandom));
  endtask

  task automatic drive(input logic v, input logic [1:0] d);
    crsdv = v;
    rxd   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int gap);
    int kind, idx, bytes, ds, dl, base;
    model(fr, kind, idx, bytes, ds, dl);
    base = edge_cnt + 1;
    for (int k = 0; k < dl; k++) exp_data.push_back('{base + ds + k, fr[ds + k]});
    if (kind != 0) exp_ev.push_back('{base + idx, kind == 1, bytes});
    foreach (fr[j]) drive(1'b1, fr[j]);
    repeat (gap) drive(1'b0, 2'($urandom));
    fr.delete();
  endtask

  task automatic reset_mid_data();
    int base;
    fr.delete();
    add(28, 2'b01); add(1, 2'b11); add_rand(10);
    base = edge_cnt + 1;
    // The last data dibit is captured on the edge just before reset hits,
    // so its output is wiped before the monitor can see it.
    for (int k = 0; k < 9; k++) exp_data.push_back('{base + 29 + k, fr[29 + k]});
    foreach (fr[j]) drive(1'b1, fr[j]);
    fr.delete();
    #1;
    rst   = 1'b1;
    crsdv = 1'b0;
    #1;
    check("rst_axiov_async", axiov, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_frame_bytes", frame_bytes, 0);
    check("rst_data_flushed", exp_data.size(), 0);
    check("rst_no_pending_event", exp_ev.size(), 0);
  endtask

  initial begin
    rst   = 1'b1;
    crsdv = 1'b0;
    rxd   = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_axiov", axiov, 0);
    check("reset_axiod", axiod, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_frame_bytes", frame_bytes, 0);
    rst = 1'b0;
    drive(1'b0, 2'b00);

    // Minimum preamble, 8 data dibits.
    add(28, 2'b01); add(1, 2'b11); add_rand(8); send_frame(1);
    // Short preamble before SFD, then a normal frame.
    add(10, 2'b01); add(1, 2'b11); add_rand(5); send_frame(1);
    add(30, 2'b01); add(1, 2'b11); add_rand(12); send_frame(1);
    // Illegal dibit inside the preamble.
    add(30, 2'b01); add(1, 2'b10); add_rand(20); send_frame(1);
    // Runt frame.
    add(28, 2'b01); add(1, 2'b11); add_rand(2); send_frame(1);
    // Bad first dibit and a preamble that just stops.
    add(1, 2'b11); add_rand(6); send_frame(1);
    add(15, 2'b01); send_frame(1);

    reset_mid_data();
    add(28, 2'b01); add(1, 2'b11); add_rand(16); send_frame(2);

    // Two 64-byte frames with a single idle cycle between them.
    add(28, 2'b01); add(1, 2'b11); add_rand(256); send_frame(1);
    add(28, 2'b01); add(1, 2'b11); add_rand(256); send_frame(1);

    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 5))
        0, 1: begin add($urandom_range(28, 40), 2'b01); add(1, 2'b11); add_rand($urandom_range(4, 100)); end
        2:    begin add($urandom_range(28, 33), 2'b01); add(1, 2'b11); add_rand($urandom_range(0, 3)); end
        3:    begin add($urandom_range(1, 27), 2'b01); add(1, 2'b11); add_rand($urandom_range(0, 10)); end
        4:    begin add($urandom_range(0, 35), 2'b01); add(1, $urandom_range(0, 1) ? 2'b10 : 2'b00); add_rand($urandom_range(0, 10)); end
        default: add($urandom_range(1, 35), 2'b01);
      endcase
      send_frame($urandom_range(1, 3));
    end

    repeat (5) drive(1'b0, 2'b00);
    check("drain_data_queue", exp_data.size(), 0);
    check("drain_event_queue", exp_ev.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ether_rx.md
ETHER_RX -- requirements
Module: ether_rx

Interface
REQ-001 Parameter MIN_PRE_DIBITS, default 28, minimum count of consecutive 2'b01 dibits required before the SFD dibit.
REQ-002 Parameter LEN_BITS, default 12, width of the frame byte-length output.
REQ-003 clk  input  1  system clock, one RMII dibit per cycle (50 MHz).
REQ-004 rst  input  1  reset; one clock, reset asynchronous and active-high.
REQ-005 crsdv  input  1  RMII carrier-sense/data-valid; high while a frame is on the wire.
REQ-006 rxd  input  2  RMII receive dibit, LSB-first order.
REQ-007 axiov  output  1  high while axiod carries a frame dibit (destination MAC onward), feeding firewall axiiv.
REQ-008 axiod  output  2  frame dibit, passed unchanged from rxd.
REQ-009 done  output  1  one-cycle pulse at end of a successfully framed packet.
REQ-010 err  output  1  one-cycle pulse when a preamble/SFD violation is detected.
REQ-011 frame_bytes  output  LEN_BITS  byte count of the last completed frame, valid from the done pulse until the next done.

Function
REQ-012 FSM states IDLE, PREAMBLE, DATA, DROP; all transitions on posedge clk.
REQ-013 IDLE: crsdv=1 and rxd=2'b01 -> PREAMBLE with pre_cnt=1; crsdv=1 with any other rxd -> DROP, err pulse.
REQ-014 PREAMBLE, crsdv=1, rxd=2'b01: pre_cnt increments, saturating at 2^$clog2(MIN_PRE_DIBITS+4)-1.
REQ-015 PREAMBLE, crsdv=1, rxd=2'b11 with pre_cnt >= MIN_PRE_DIBITS: -> DATA (SFD dibit is not forwarded).
REQ-016 PREAMBLE, crsdv=1, rxd=2'b11 with pre_cnt < MIN_PRE_DIBITS, or rxd in {2'b00, 2'b10}: -> DROP, err pulses one cycle later.
REQ-017 DATA, crsdv=1: dibit forwarded; dibit counter increments, wrapping modulo 2^(LEN_BITS+2).
REQ-018 DATA, crsdv=0: -> IDLE; done pulses one cycle later if dibit count >= 4, else err pulses; frame_bytes loads dibit_count>>2 on the same edge as done.
REQ-019 DROP: holds until crsdv=0, then -> IDLE; no axiov, done or err while in DROP.
REQ-020 PREAMBLE, crsdv=0: -> IDLE silently (no err).
REQ-021 Output latency exactly one cycle: axiov(t+1) = (state(t)==DATA && crsdv(t)); axiod(t+1) = rxd(t), registered every cycle.
REQ-022 axiov deasserts on the cycle after crsdv falls; a gap of one low crsdv cycle always ends the frame.
REQ-023 done and err are never high in the same cycle; each is high for at most one cycle per frame.
REQ-024 Back-to-back frames: IDLE accepts a new preamble on the cycle immediately after returning from DATA/DROP.

Reset
REQ-025 rst high asynchronously forces state=IDLE, pre_cnt=0, dibit count=0, axiov=0, axiod=2'b00, done=0, err=0, frame_bytes=0.
REQ-026 Reset mid-frame aborts the frame with no done/err; after rst deasserts, the block sits in IDLE, or enters DROP if crsdv is high with rxd!=2'b01.

Structure
REQ-027 Shared package ether_pkg holds the state enum typedef, PREAMBLE_DIBIT=2'b01 and SFD_DIBIT=2'b11.
REQ-028 Single flat module, no sub-modules; axiov/axiod are registered outputs, not combinational.

Verification
REQ-029 28x 01, then 11, then 8 data dibits, then crsdv=0 -> axiov high 8 cycles starting one cycle after the SFD, axiod matches input, done pulses, frame_bytes=2.
REQ-030 10x 01 then 11 -> err pulses, axiov stays 0 until crsdv falls; a following valid frame is received normally.
REQ-031 30x 01, then 10, then 20 more dibits -> err pulses once, no axiov, state returns to IDLE when crsdv falls.
REQ-032 Valid preamble + SFD, 2 data dibits, crsdv=0 -> axiov high 2 cycles, err pulses (runt), done stays 0.
REQ-033 rst asserted asynchronously mid-DATA (between clock edges) -> axiov=0 immediately, no done, next frame received intact.
REQ-034 Two valid 64-byte frames separated by a single crsdv=0 cycle -> two done pulses, frame_bytes=64 each time, 256 axiov cycles per frame.
